msb_power_sequencer: RTL and testbench

Power-gating controller for the upper 16-bit half of the 32-bit ripple-carry adder. It watches operand traffic, powers the MSB domain down after a programmable idle window, and sequences the domain's isolation, retention and power-switch controls in a fixed safe order. On a new operation or a software override it wakes the domain and holds the requester off with a valid/ready handshake until the domain is usable. It sits between the operand source and the adder's `iso_en`/`ret_en`/`pse` inputs, replacing hand-driven `flag` control.

---
 rtl/msb_pseq_pkg.sv | 41 ++++
 rtl/msb_power_sequencer_if.sv | 9 +
 rtl/msb_pseq_timer.sv | 40 ++++
 rtl/msb_power_sequencer.sv | 123 ++++++++++++
 tb/tb_msb_power_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/msb_pseq_pkg.sv
// rtl/msb_pseq_pkg.sv - state encodings, default timings and output decode for the MSB power sequencer
package msb_pseq_pkg;

  typedef enum logic [2:0] {
    ST_ON      = 3'd0,
    ST_ISO     = 3'd1,
    ST_SAVE    = 3'd2,
    ST_OFF     = 3'd3,
    ST_PWRUP   = 3'd4,
    ST_RESTORE = 3'd5
  } pseq_state_e;

  localparam int unsigned DEF_IDLE_CYCLES = 16;
  localparam int unsigned DEF_ISO_SETUP   = 2;
  localparam int unsigned DEF_PSW_SETTLE  = 4;
  localparam int unsigned DEF_CNT_W       = 8;

  typedef struct packed {
    logic op_ready;
    logic iso_en;
    logic ret_en;
    logic pse;
    logic msb_on;
  } pseq_out_t;

  function automatic pseq_out_t decode_outputs(pseq_state_e s);
    pseq_out_t o;
    o = '{op_ready: 1'b0, iso_en: 1'b1, ret_en: 1'b1, pse: 1'b1, msb_on: 1'b0};
    case (s)
      ST_ON:      o = '{op_ready: 1'b1, iso_en: 1'b0, ret_en: 1'b0, pse: 1'b1, msb_on: 1'b1};
      ST_ISO:     o.ret_en = 1'b0;
      ST_SAVE:    o.ret_en = 1'b1;
      ST_OFF:     o.pse = 1'b0;
      ST_PWRUP:   o.pse = 1'b1;
      ST_RESTORE: o.ret_en = 1'b0;
      default:    o = '{op_ready: 1'b1, iso_en: 1'b0, ret_en: 1'b0, pse: 1'b1, msb_on: 1'b1};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/msb_power_sequencer_if.sv
// rtl/msb_power_sequencer_if.sv - requester handshake between operand source and MSB power sequencer
interface msb_power_sequencer_if;
  logic op_valid;
  logic force_on;
  logic op_ready;

  modport master (output op_valid, output force_on, input op_ready);
  modport slave  (input op_valid, input force_on, output op_ready);
endinterface

// File: rtl/msb_pseq_timer.sv
// rtl/msb_pseq_timer.sv - loadable down-counter with a one-cycle done pulse
module msb_pseq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // Loading N gives done in the (N+1)-th cycle after the load edge.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = load_val_i;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/msb_power_sequencer.sv
// rtl/msb_power_sequencer.sv - power-gating sequencer for the adder MSB half; MSB_PSEQ_STATS_EN adds pd_cnt/off_cyc
module msb_power_sequencer
  import msb_pseq_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int unsigned ISO_SETUP   = DEF_ISO_SETUP,
  parameter int unsigned PSW_SETTLE  = DEF_PSW_SETTLE,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  msb_power_sequencer_if.slave  req,
  output logic                  iso_en,
  output logic                  ret_en,
  output logic                  pse,
  output logic                  msb_on,
  output logic [2:0]            state_o
`ifdef MSB_PSEQ_STATS_EN
  ,
  output logic [15:0]           pd_cnt,
  output logic [31:0]           off_cyc
`endif
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LOAD  = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] PSW_LOAD  = CNT_W'(PSW_SETTLE - 1);

  pseq_state_e      state_q, state_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  pseq_out_t        out_q;
  logic             wake;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  assign wake = req.op_valid | req.force_on;

  msb_pseq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_ON: begin
        if (wake) begin
          idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
          state_d  = ST_ISO;
          tmr_load = 1'b1;
          tmr_val  = ISO_LOAD;
        end else if (idle_q != '1) begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_ISO: begin
        if (wake)          state_d = ST_ON;
        else if (tmr_done) state_d = ST_SAVE;
      end
      ST_SAVE: state_d = ST_OFF;
      ST_OFF: begin
        if (wake) begin
          state_d  = ST_PWRUP;
          tmr_load = 1'b1;
          tmr_val  = PSW_LOAD;
        end
      end
      ST_PWRUP:   if (tmr_done) state_d = ST_RESTORE;
      ST_RESTORE: state_d = ST_ON;
      default:    state_d = ST_ON;
    endcase
    // A fresh idle window starts on every return to ON.
    if (state_d == ST_ON && state_q != ST_ON) idle_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ON;
      idle_q  <= '0;
      out_q   <= decode_outputs(ST_ON);
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  assign req.op_ready = out_q.op_ready;
  assign iso_en       = out_q.iso_en;
  assign ret_en       = out_q.ret_en;
  assign pse          = out_q.pse;
  assign msb_on       = out_q.msb_on;
  assign state_o      = state_q;

`ifdef MSB_PSEQ_STATS_EN
  logic [15:0] pd_cnt_q;
  logic [31:0] off_cyc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pd_cnt_q  <= '0;
      off_cyc_q <= '0;
    end else begin
      if (state_d == ST_OFF && state_q != ST_OFF && pd_cnt_q != '1)
        pd_cnt_q <= pd_cnt_q + 16'd1;
      if (!out_q.pse && off_cyc_q != '1)
        off_cyc_q <= off_cyc_q + 32'd1;
    end
  end

  assign pd_cnt  = pd_cnt_q;
  assign off_cyc = off_cyc_q;
`endif

endmodule

// File: tb/tb_msb_power_sequencer.sv
// tb/tb_msb_power_sequencer.sv - directed and random checks of msb_power_sequencer against a plan-queue model (MSB_PSEQ_STATS_EN aware)
module tb_msb_power_sequencer;

  localparam int IDLE = 16;
  localparam int ISO_N = 2;
  localparam int PSW_N = 4;
  localparam int S_ON = 0, S_ISO = 1, S_SAVE = 2, S_OFF = 3, S_PWRUP = 4, S_RESTORE = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic iso_en, ret_en, pse, msb_on;
  logic [2:0] state_o;
`ifdef MSB_PSEQ_STATS_EN
  logic [15:0] pd_cnt;
  logic [31:0] off_cyc;
`endif

  always #5 clk = ~clk;

  msb_power_sequencer_if bus();

  msb_power_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus),
    .iso_en  (iso_en),
    .ret_en  (ret_en),
    .pse     (pse),
    .msb_on  (msb_on),
    .state_o (state_o)
`ifdef MSB_PSEQ_STATS_EN
    ,
    .pd_cnt  (pd_cnt),
    .off_cyc (off_cyc)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: current state plus a queue of already-committed future states.
  int cur = S_ON;
  int idle_run = 0;
  int plan[$];
  int m_pd = 0;
  longint m_off = 0;
  logic acc = 1'b0;
  logic last_edge_rst = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {op_ready, iso_en, ret_en, pse, msb_on, state[2:0]}
  function automatic logic [7:0] expect_vec(int s);
    case (s)
      S_ON:      return 8'b1_0_0_1_1_000;
      S_ISO:     return 8'b0_1_0_1_0_001;
      S_SAVE:    return 8'b0_1_1_1_0_010;
      S_OFF:     return 8'b0_1_1_0_0_011;
      S_PWRUP:   return 8'b0_1_1_1_0_100;
      S_RESTORE: return 8'b0_1_0_1_0_101;
      default:   return 8'hxx;
    endcase
  endfunction

  task automatic model_update(input logic ov, input logic fo, input logic rn);
    int prev;
    logic [7:0] ev;
    logic wake;
    if (!rn) begin
      cur = S_ON; idle_run = 0; plan.delete(); m_pd = 0; m_off = 0;
      return;
    end
    ev = expect_vec(cur);
    if (!ev[4] && m_off < 64'hFFFF_FFFF) m_off++;
    prev = cur;
    wake = ov | fo;
    case (cur)
      S_ON: begin
        if (wake) idle_run = 0;
        else begin
          idle_run++;
          if (idle_run == IDLE) begin
            plan.delete();
            repeat (ISO_N) plan.push_back(S_ISO);
            plan.push_back(S_SAVE);
            plan.push_back(S_OFF);
            cur = plan.pop_front();
          end
        end
      end
      S_ISO: begin
        if (wake) begin plan.delete(); cur = S_ON; end
        else cur = plan.pop_front();
      end
      S_OFF: begin
        if (wake) begin
          repeat (PSW_N) plan.push_back(S_PWRUP);
          plan.push_back(S_RESTORE);
          plan.push_back(S_ON);
          cur = plan.pop_front();
        end
      end
      default: cur = plan.pop_front();
    endcase
    if (cur == S_ON && prev != S_ON) idle_run = 0;
    if (cur == S_OFF && prev != S_OFF && m_pd < 65535) m_pd++;
  endtask

  task automatic step(input logic ov, input logic fo, input logic rn);
    bus.op_valid = ov;
    bus.force_on = fo;
    rst_n = rn;
    acc = ov && rn && (cur == S_ON);
    @(posedge clk);
    last_edge_rst = !rn;
    model_update(ov, fo, rn);
    #1;
    check("outputs", {24'd0, bus.op_ready, iso_en, ret_en, pse, msb_on, state_o}, {24'd0, expect_vec(cur)});
`ifdef MSB_PSEQ_STATS_EN
    check("pd_cnt", {16'd0, pd_cnt}, m_pd[31:0]);
    check("off_cyc", off_cyc, m_off[31:0]);
`endif
  endtask

  task automatic idle_until(input logic [2:0] st, output int n);
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end while (state_o != st && n < 100);
  endtask

  task automatic wake_until_ready(output int n, output int n_ret);
    n = 0; n_ret = 0;
    do begin
      step(1'b1, 1'b0, 1'b1);
      n++;
      if (!ret_en && n_ret == 0) n_ret = n;
    end while (!bus.op_ready && n < 20);
  endtask

  // Ordering invariants, evaluated on the levels held before each change.
  logic p_iso = 1'b0, p_ret = 1'b0, p_pse = 1'b1;
  always @(negedge clk) begin
    if (!last_edge_rst) begin
      if (p_pse && !pse)
        check("pse_fall_order", {28'd0, p_iso, p_ret, iso_en, ret_en}, 32'hF);
      if (p_iso && !iso_en)
        check("iso_fall_order", {28'd0, p_pse, p_ret, pse, ret_en}, 32'hA);
    end
    p_iso = iso_en; p_ret = ret_en; p_pse = pse;
  end

  initial begin
    int n, n_ret, bad;
    logic ov_r, fo_r, rn_r;
    bus.op_valid = 1'b0;
    bus.force_on = 1'b0;
    rst_n = 1'b0;

    step(1'b0, 1'b0, 1'b0);
    check("reset_vec", {24'd0, bus.op_ready, iso_en, ret_en, pse, msb_on, state_o}, 32'h98);

    // Power-down timing
    idle_until(3'd1, n);
    check("idle_to_iso", n, IDLE);
    idle_until(3'd3, n);
    check("iso_to_pse_low", n, ISO_N + 1);
    check("off_pse", {31'd0, pse}, 0);

    // Wake from OFF
    wake_until_ready(n, n_ret);
    check("wake_ready_lat", n, PSW_N + 2);
    check("wake_ret_lat", n_ret, PSW_N + 1);
    check("wake_iso", {31'd0, iso_en}, 0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Abort during second ISO cycle
    idle_until(3'd1, n);
    step(1'b0, 1'b0, 1'b1);
    check("iso_second", {29'd0, state_o}, S_ISO);
    step(1'b1, 1'b0, 1'b1);
    check("abort_state", {29'd0, state_o}, S_ON);
    check("abort_ready", {31'd0, bus.op_ready}, 1);
    step(1'b1, 1'b0, 1'b1);

    // force_on hold and release
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (state_o != 3'd0) bad++;
    end
    check("force_on_stays", bad, 0);
    idle_until(3'd1, n);
    check("release_to_iso", n, IDLE);

    // Reset during PWRUP
    idle_until(3'd3, n);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("in_pwrup", {29'd0, state_o}, S_PWRUP);
    step(1'b1, 1'b0, 1'b0);
    check("pwrup_reset_vec", {24'd0, bus.op_ready, iso_en, ret_en, pse, msb_on, state_o}, 32'h98);
    idle_until(3'd1, n);
    check("post_reset_idle", n, IDLE);

    // Two full sleep/wake cycles from reset
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      idle_until(3'd3, n);
      wake_until_ready(n, n_ret);
      step(1'b1, 1'b0, 1'b1);
    end
`ifdef MSB_PSEQ_STATS_EN
    check("pd_cnt_two", {16'd0, pd_cnt}, 2);
`endif

    // Random traffic
    ov_r = 1'b0; fo_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(ov_r && !acc)) ov_r = ($urandom_range(0, 24) == 0);
      if (fo_r) fo_r = ($urandom_range(0, 9) != 0);
      else      fo_r = ($urandom_range(0, 149) == 0);
      rn_r = ($urandom_range(0, 299) != 0);
      if (!rn_r) ov_r = 1'b0;
      step(ov_r, fo_r, rn_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
